// File: rtl/sum_fifo_pkg.sv
// Shared widths, default depth and helpers for the adder-result FIFO.
package sum_fifo_pkg;
  localparam int DATA_W    = 9;
  localparam int ACC_W     = 12;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  typedef logic [PTR_W-1:0] ptr_t;

  // Entry layout keeps the carry in the MSB so it reads as a 9-bit sum.
  function automatic logic [DATA_W-1:0] pack_entry(input logic cout, input logic [7:0] sum);
    return {cout, sum};
  endfunction
endpackage

// File: rtl/sum_fifo_ram.sv
// Result storage: one synchronous write port, one asynchronous read port, no reset.
module sum_fifo_ram
  import sum_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sum_result_fifo.sv
// Adder-result FIFO with sticky overflow flag and an optional running accumulator
// enabled by defining SUM_FIFO_ACCUM_EN (acc_out is tied to 0 otherwise).
module sum_result_fifo
  import sum_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [7:0]                 in_sum,
  input  logic                       in_cout,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [ACC_W-1:0]           acc_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;
  logic [DATA_W-1:0] rd_data;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // in_ready depends only on occupancy, ena and reset, never on out_ready, so a
  // full FIFO refuses a push even while the head is being popped that cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = rst_n & ena & ~full;
  assign out_valid = ena & (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (ena && in_valid && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  sum_fifo_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_ptr_q),
    .wdata (pack_entry(in_cout, in_sum)),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign out_data = rd_data;
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef SUM_FIFO_ACCUM_EN
  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)       acc_d = '0;
    else if (push) acc_d = acc_q + ACC_W'(pack_entry(in_cout, in_sum));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_out = acc_q;
`else
  assign acc_out = '0;
`endif
endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed bench for sum_result_fifo: scoreboard queue of expected entries plus
// occupancy / overflow / accumulator model, checked with immediate assertions.
module tb_sum_result_fifo;
  import sum_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_sum = 8'h00;
  logic        in_cout = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [8:0]  out_data;
  logic [2:0]  count;
  logic        overflow;
  logic [11:0] acc_out;

  logic [8:0]  exp_q[$];
  int          m_cnt;
  logic        m_ovf;
  logic [11:0] m_acc;
  int          n_assert;
  int          n_fail;

  sum_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check handshake/head before the edge, update model, check state after.
  task automatic cyc(input logic v, input logic [8:0] d, input logic ordy, input logic c);
    logic push_m, pop_m, full_m;
    in_valid  = v;
    in_cout   = d[8];
    in_sum    = d[7:0];
    out_ready = ordy;
    clr       = c;
    #1;
    full_m = (m_cnt == DEPTH);
    push_m = ena && v && !full_m && !c;
    pop_m  = ena && ordy && (m_cnt != 0) && !c;
    check("in_ready", 32'(in_ready), 32'(ena && !full_m));
    check("out_valid", 32'(out_valid), 32'(ena && (m_cnt != 0)));
    if (ena && ordy && (m_cnt != 0)) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 32'(1), 32'(0));
      else check("out_data", 32'(out_data), 32'(exp_q[0]));
    end
    @(posedge clk);
    #1;
    if (c) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_acc = '0;
    end else begin
      if (pop_m) begin
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (push_m) begin
        exp_q.push_back(d);
        m_cnt++;
`ifdef SUM_FIFO_ACCUM_EN
        m_acc = m_acc + 12'(d);
`endif
      end
      if (ena && v && full_m) m_ovf = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    check("count", 32'(count), 32'(m_cnt));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("acc_out", 32'(acc_out), 32'(m_acc));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_ovf    = 1'b0;
    m_acc    = '0;

    // Reset state while reset is held, with ena high.
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_acc", 32'(acc_out), 32'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single push of {1, 0xFF} with the consumer always ready.
    cyc(1'b1, 9'h1FF, 1'b1, 1'b0);
    check("s1_valid", 32'(out_valid), 32'(1));
    check("s1_data", 32'(out_data), 32'h1FF);
    check("s1_count1", 32'(count), 32'(1));
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    check("s1_count0", 32'(count), 32'(0));

    // Fill past capacity with the consumer stalled, then drain.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 9'(i), 1'b0, 1'b0);
      if (i == 4) begin
        check("s2_full_ready", 32'(in_ready), 32'(0));
        check("s2_full_count", 32'(count), 32'(4));
        check("s2_no_ovf_yet", 32'(overflow), 32'(0));
      end
    end
    check("s2_overflow", 32'(overflow), 32'(1));
    check("s2_head_held", 32'(out_data), 32'h001);
    for (int i = 0; i < 4; i++) cyc(1'b0, 9'h000, 1'b1, 1'b0);
    check("s2_drained", 32'(out_valid), 32'(0));
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    cyc(1'b1, 9'h0A1, 1'b0, 1'b0);
    cyc(1'b1, 9'h1A2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 9'($urandom_range(0, 511)), 1'b1, 1'b0);
    check("s3_count", 32'(count), 32'(2));

    // clr with in_valid high while count=3 and overflow set.
    cyc(1'b1, 9'h033, 1'b0, 1'b0);
    check("s4_pre_count", 32'(count), 32'(3));
    check("s4_pre_ovf", 32'(overflow), 32'(1));
    cyc(1'b1, 9'h044, 1'b0, 1'b1);
    check("s4_count", 32'(count), 32'(0));
    check("s4_ovf", 32'(overflow), 32'(0));
    check("s4_acc", 32'(acc_out), 32'(0));
    check("s4_no_push", 32'(out_valid), 32'(0));

    // Sixteen pushes of 0x1FF feed the accumulator.
    for (int i = 0; i < 16; i++) cyc(1'b1, 9'h1FF, 1'b1, 1'b0);
`ifdef SUM_FIFO_ACCUM_EN
    check("s5_acc", 32'(acc_out), 32'hFF0);
`else
    check("s5_acc", 32'(acc_out), 32'h000);
`endif
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    // ena low freezes everything and blocks both handshakes.
    cyc(1'b1, 9'h055, 1'b0, 1'b0);
    cyc(1'b1, 9'h066, 1'b0, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 9'h077, 1'b1, 1'b0);
    check("s6_hold_count", 32'(count), 32'(2));
    ena = 1'b1;
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    // Asynchronous reset mid-burst, between clock edges.
    cyc(1'b1, 9'h011, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_sum   = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    check("s7_count", 32'(count), 32'(0));
    check("s7_in_ready", 32'(in_ready), 32'(0));
    check("s7_out_valid", 32'(out_valid), 32'(0));
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_acc = '0;
    @(posedge clk);
    #1;
    check("s7_held_count", 32'(count), 32'(0));
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    cyc(1'b1, 9'h0AA, 1'b0, 1'b0);
    check("s7_post_valid", 32'(out_valid), 32'(1));
    check("s7_post_data", 32'(out_data), 32'h0AA);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
